// File: rtl/fifo_drain.sv
// fifo_drain -- read-side controller for the byte FIFO.
//
// Watches the FIFO empty flag, issues rd_en, captures buf_out one cycle after
// each accepted read into a 2-entry skid buffer, and presents the bytes on a
// valid/ready interface. Also keeps a wrapping byte count and an XOR checksum
// of every captured byte.
//
// Ports:
//   clk        FIFO read clock, all logic on its rising edge
//   rst        synchronous active-high reset
//   enable     permits new FIFO reads
//   clr        synchronous clear of rd_count and xor_sum only
//   empty      FIFO empty flag
//   buf_out    FIFO read data, valid the edge after an accepted read
//   rd_en      FIFO read strobe (combinational, depends on out_ready)
//   out_data   head of the skid buffer
//   out_valid  out_data is valid
//   out_ready  downstream accepts
//   rd_count   bytes captured, mod 2^CNT_W
//   xor_sum    XOR of all captured bytes
//   busy       FSM not idle or buffer not empty
module fifo_drain #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              clr,
   input  logic              empty,
   input  logic [DATA_W-1:0] buf_out,
   output logic              rd_en,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  rd_count,
   output logic [DATA_W-1:0] xor_sum,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        occ_q, occ_d;
   logic              infl_q, infl_d;
   logic [DATA_W-1:0] head_q, head_d;
   logic [DATA_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] xor_q, xor_d;

   logic              pop;
   logic [2:0]        occ_after;

   always_comb begin
      pop = (occ_q != 2'd0) & out_ready;

      // Occupancy after this edge; a new read is only issued if its byte
      // will still find a free slot, so occupancy can never exceed 2.
      occ_after = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
      rd_en     = !rst & (state_q == RUN) & !empty & (occ_after < 3'd2);
      infl_d    = rd_en;
      occ_d     = occ_after[1:0];

      state_d = state_q;
      unique case (state_q)
         IDLE:    if (enable) state_d = RUN;
         RUN:     if (!enable) state_d = rd_en ? STOP : IDLE;
         STOP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Two-slot buffer: head is presented, tail holds the second entry.
      head_d = head_q;
      tail_d = tail_q;
      unique case ({infl_q, pop})
         2'b10: begin
            if (occ_q == 2'd0) head_d = buf_out;
            else               tail_d = buf_out;
         end
         2'b01: head_d = tail_q;
         2'b11: begin
            if (occ_q == 2'd1) begin
               head_d = buf_out;
            end else begin
               head_d = tail_q;
               tail_d = buf_out;
            end
         end
         default: ;
      endcase

      cnt_d = cnt_q;
      xor_d = xor_q;
      if (clr) begin
         cnt_d = '0;
         xor_d = '0;
      end else if (infl_q) begin
         cnt_d = cnt_q + 1'b1;
         xor_d = xor_q ^ buf_out;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         occ_q   <= '0;
         infl_q  <= 1'b0;
         head_q  <= '0;
         tail_q  <= '0;
         cnt_q   <= '0;
         xor_q   <= '0;
      end else begin
         state_q <= state_d;
         occ_q   <= occ_d;
         infl_q  <= infl_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         cnt_q   <= cnt_d;
         xor_q   <= xor_d;
      end
   end

   assign out_data  = head_q;
   assign out_valid = (occ_q != 2'd0);
   assign rd_count  = cnt_q;
   assign xor_sum   = xor_q;
   assign busy      = (state_q != IDLE) | (occ_q != 2'd0);

endmodule

// File: tb/tb_fifo_drain.sv
// Bench for fifo_drain. The bench plays the FIFO (a byte queue), drives a
// default instance and a CNT_W=4 instance with the same stimulus, and keeps a
// queue-level model of the expected outputs checked on every falling edge.
module tb_fifo_drain;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1, enable = 1'b0, clr = 1'b0, empty = 1'b1, out_ready = 1'b0;
   logic [7:0] buf_out = '0;

   logic        rd_en, out_valid, busy;
   logic [7:0]  out_data, xor_sum;
   logic [15:0] rd_count;
   logic        rd_en4, out_valid4, busy4;
   logic [7:0]  out_data4, xor_sum4;
   logic [3:0]  rd_count4;

   fifo_drain #(.DATA_W(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .enable(enable), .clr(clr), .empty(empty),
      .buf_out(buf_out), .rd_en(rd_en), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .rd_count(rd_count),
      .xor_sum(xor_sum), .busy(busy));

   fifo_drain #(.DATA_W(8), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .enable(enable), .clr(clr), .empty(empty),
      .buf_out(buf_out), .rd_en(rd_en4), .out_data(out_data4),
      .out_valid(out_valid4), .out_ready(out_ready), .rd_count(rd_count4),
      .xor_sum(xor_sum4), .busy(busy4));

   int checks = 0, failures = 0;

   logic [7:0] src[$];          // FIFO contents
   logic [7:0] got[$];          // bytes taken downstream
   int         rd_cycles[$];    // cycle numbers with rd_en high
   int         out_cycles[$];   // cycle numbers with a downstream transfer
   bit         force_empty = 1'b0;
   bit         chk_en = 1'b0;
   bit         acc = 1'b0;
   int         ncyc = 0;
   logic [7:0] exp_s [5] = '{8'd12, 8'd24, 8'd2, 8'd4, 8'd0};

   // model state
   int          m_state = 0;    // 0 idle, 1 run, 2 stop
   bit          m_infl = 1'b0;
   logic [31:0] m_cnt = '0;
   logic [7:0]  m_xor = '0;
   logic [7:0]  bq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic upd();
      empty = force_empty || (src.size() == 0);
   endtask

   // One clock: after the edge, the FIFO presents the byte for an accepted read.
   task automatic cyc();
      @(posedge clk);
      #1;
      if (acc && src.size() != 0) buf_out = src.pop_front();
      upd();
   endtask

   always @(negedge clk) begin : cmp
      bit pop_m, rd_m, valid_m, busy_m;
      ncyc++;
      pop_m   = (bq.size() != 0) && out_ready;
      rd_m    = !rst && m_state == 1 && !empty &&
                (int'(bq.size()) + int'(m_infl) - int'(pop_m) < 2);
      valid_m = (bq.size() != 0);
      busy_m  = (m_state != 0) || valid_m;
      if (chk_en) begin
         chk("rd_en", {31'b0, rd_en}, {31'b0, rd_m});
         chk("out_valid", {31'b0, out_valid}, {31'b0, valid_m});
         if (valid_m) chk("out_data", {24'b0, out_data}, {24'b0, bq[0]});
         chk("rd_count", {16'b0, rd_count}, {16'b0, m_cnt[15:0]});
         chk("xor_sum", {24'b0, xor_sum}, {24'b0, m_xor});
         chk("busy", {31'b0, busy}, {31'b0, busy_m});
         chk("w4_rd_en", {31'b0, rd_en4}, {31'b0, rd_m});
         chk("w4_out_valid", {31'b0, out_valid4}, {31'b0, valid_m});
         chk("w4_rd_count", {28'b0, rd_count4}, {28'b0, m_cnt[3:0]});
         chk("occ_le_2", {31'b0, dut.occ_q <= 2'd2}, 32'd1);
         chk("model_occ_le_2", {31'b0, bq.size() <= 2}, 32'd1);
      end
      if (rd_en) rd_cycles.push_back(ncyc);
      if (out_valid && out_ready) begin
         got.push_back(out_data);
         out_cycles.push_back(ncyc);
      end
      acc = rd_en;
      if (rst) begin
         m_state = 0; m_infl = 1'b0; m_cnt = '0; m_xor = '0;
         bq.delete();
      end else begin
         if (pop_m) bq.delete(0);
         if (m_infl) begin
            bq.push_back(buf_out);
            m_cnt = m_cnt + 1;
            m_xor = m_xor ^ buf_out;
         end
         if (clr) begin
            m_cnt = '0; m_xor = '0;
         end
         case (m_state)
            0: if (enable) m_state = 1;
            1: if (!enable) m_state = rd_m ? 2 : 0;
            default: m_state = 0;
         endcase
         m_infl = rd_m;
      end
   end

   initial begin
      int rb, ob;
      // Reset held with data available and enable high
      rst = 1'b1; enable = 1'b1; out_ready = 1'b1;
      src.push_back(8'd99); upd();
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk_en = 1'b1;
         chk("rst_rd_en", {31'b0, rd_en}, 32'd0);
         chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
         chk("rst_out_data", {24'b0, out_data}, 32'd0);
         chk("rst_rd_count", {16'b0, rd_count}, 32'd0);
         chk("rst_xor_sum", {24'b0, xor_sum}, 32'd0);
         chk("rst_busy", {31'b0, busy}, 32'd0);
      end
      src.delete(); upd();

      // Streaming
      rb = rd_cycles.size(); ob = got.size();
      src = '{8'd12, 8'd24, 8'd2, 8'd4, 8'd0}; upd();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) cyc();
      chk("stream_reads", rd_cycles.size() - rb, 32'd5);
      chk("stream_outs", got.size() - ob, 32'd5);
      if (rd_cycles.size() - rb == 5 && got.size() - ob == 5) begin
         chk("stream_rd_consecutive", rd_cycles[rb+4] - rd_cycles[rb], 32'd4);
         chk("stream_latency", out_cycles[ob] - rd_cycles[rb], 32'd2);
         chk("stream_out_consecutive", out_cycles[ob+4] - out_cycles[ob], 32'd4);
         for (int i = 0; i < 5; i++) chk("stream_byte", {24'b0, got[ob+i]}, {24'b0, exp_s[i]});
      end
      chk("stream_rd_count", {16'b0, rd_count}, 32'd5);
      chk("stream_xor_sum", {24'b0, xor_sum}, 32'h12);   // 12^24^2^4^0

      // Backpressure
      rb = rd_cycles.size();
      out_ready = 1'b0;
      src = '{8'd12, 8'd24, 8'd2, 8'd4, 8'd0}; upd();
      for (int i = 0; i < 6; i++) begin
         cyc();
         if (i >= 1) begin
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_hold", {24'b0, out_data}, 32'd12);
         end
      end
      chk("bp_reads", rd_cycles.size() - rb, 32'd2);
      chk("bp_occ", {30'b0, dut.occ_q}, 32'd2);
      chk("bp_src_left", src.size(), 32'd3);
      ob = got.size();
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) cyc();
      chk("bp_outs", got.size() - ob, 32'd5);
      if (got.size() - ob == 5)
         for (int i = 0; i < 5; i++) chk("bp_byte", {24'b0, got[ob+i]}, {24'b0, exp_s[i]});
      chk("bp_rd_count", {16'b0, rd_count}, 32'd10);

      // Stop with a read in flight: enable drops in the cycle the read is accepted
      rb = rd_cycles.size();
      src = '{8'hA5, 8'h5A, 8'h33}; upd();
      enable = 1'b0;
      cyc();
      chk("stop_busy", {31'b0, busy}, 32'd1);
      chk("stop_valid", {31'b0, out_valid}, 32'd0);
      chk("stop_rd_en", {31'b0, rd_en}, 32'd0);
      cyc();
      chk("stop_capture_valid", {31'b0, out_valid}, 32'd1);
      chk("stop_capture_data", {24'b0, out_data}, 32'hA5);
      chk("stop_capture_rd_en", {31'b0, rd_en}, 32'd0);
      cyc();
      chk("stop_idle_busy", {31'b0, busy}, 32'd0);
      for (int i = 0; i < 3; i++) cyc();
      chk("stop_reads", rd_cycles.size() - rb, 32'd1);
      chk("stop_rd_count", {16'b0, rd_count}, 32'd11);
      src.delete(); upd();

      // Clear and wrap
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      chk("clr_rd_count", {16'b0, rd_count}, 32'd0);
      chk("clr_rd_count_w4", {28'b0, rd_count4}, 32'd0);
      enable = 1'b1;
      for (int i = 0; i < 17; i++) src.push_back(8'(i * 7 + 1));
      upd();
      for (int i = 0; i < 25; i++) cyc();
      chk("wrap_rd_count_w4", {28'b0, rd_count4}, 32'd1);
      chk("wrap_rd_count", {16'b0, rd_count}, 32'd17);
      src.push_back(8'h77); upd();
      cyc();                    // read accepted
      clr = 1'b1;
      cyc();                    // byte captured with clr high
      clr = 1'b0;
      chk("clrcap_rd_count", {16'b0, rd_count}, 32'd0);
      chk("clrcap_rd_count_w4", {28'b0, rd_count4}, 32'd0);
      chk("clrcap_xor_sum", {24'b0, xor_sum}, 32'd0);
      chk("clrcap_valid", {31'b0, out_valid}, 32'd1);
      chk("clrcap_data", {24'b0, out_data}, 32'h77);

      // Random traffic against the model
      for (int i = 0; i < 10000; i++) begin
         cyc();
         rst         = ($urandom_range(0, 499) == 0);
         enable      = ($urandom_range(0, 9) < 8);
         out_ready   = ($urandom_range(0, 9) < 6);
         clr         = ($urandom_range(0, 99) == 0);
         force_empty = ($urandom_range(0, 9) < 3);
         if (src.size() < 4 && $urandom_range(0, 1) == 1)
            src.push_back(8'($urandom_range(0, 255)));
         upd();
      end
      rst = 1'b0; clr = 1'b0; force_empty = 1'b0; upd();
      for (int i = 0; i < 10; i++) cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
